// File: rtl/sample_block_counter.sv
// Multi-channel sample block counter with shared terminal count, wrap or
// saturate-and-hold modes, sticky overrun per channel and a block-done summary.
module sample_block_counter #(
  parameter int NUM_BITS = 10,
  parameter int NUM_CH   = 2
) (
  input  logic                         clk,
  input  logic                         n_reset,
  input  logic                         clear,
  input  logic [NUM_CH-1:0]            cnt_up,
  input  logic [NUM_BITS-1:0]          rollover_val,
  input  logic                         one_shot,
  output logic [NUM_CH*NUM_BITS-1:0]   count_out,
  output logic [NUM_CH-1:0]            rollover_flag,
  output logic [NUM_CH-1:0]            overrun,
  output logic                         block_done
);

  logic [NUM_BITS-1:0] count_q [NUM_CH];
  logic [NUM_BITS-1:0] count_d [NUM_CH];
  logic [NUM_CH-1:0]   flag_q, flag_d;
  logic [NUM_CH-1:0]   ovr_q, ovr_d;
  logic [NUM_CH-1:0]   reached_q, reached_d;
  logic                done_q, done_d;

  always_comb begin
    flag_d    = flag_q;
    ovr_d     = ovr_q;
    reached_d = reached_q;
    for (int i = 0; i < NUM_CH; i++) begin
      count_d[i] = count_q[i];
    end

    if (clear) begin
      flag_d    = '0;
      ovr_d     = '0;
      reached_d = '0;
      for (int i = 0; i < NUM_CH; i++) begin
        count_d[i] = '0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (!cnt_up[i]) begin
          // The one-shot flag is a level; the wrap flag is a single-cycle pulse.
          if (!one_shot) begin
            flag_d[i] = 1'b0;
          end
        end else if (!one_shot) begin
          if (count_q[i] >= rollover_val) begin
            count_d[i]   = '0;
            flag_d[i]    = 1'b1;
            reached_d[i] = 1'b1;
          end else begin
            count_d[i] = count_q[i] + 1'b1;
            flag_d[i]  = 1'b0;
          end
        end else begin
          if (count_q[i] >= rollover_val) begin
            // Already at or beyond terminal: hold and record the extra enable.
            ovr_d[i]     = 1'b1;
            flag_d[i]    = 1'b1;
            reached_d[i] = 1'b1;
          end else begin
            count_d[i] = count_q[i] + 1'b1;
            if ((count_q[i] + 1'b1) == rollover_val) begin
              flag_d[i]    = 1'b1;
              reached_d[i] = 1'b1;
            end else begin
              flag_d[i] = 1'b0;
            end
          end
        end
      end
    end

    done_d = &reached_d;
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      flag_q    <= '0;
      ovr_q     <= '0;
      reached_q <= '0;
      done_q    <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        count_q[i] <= '0;
      end
    end else begin
      flag_q    <= flag_d;
      ovr_q     <= ovr_d;
      reached_q <= reached_d;
      done_q    <= done_d;
      for (int i = 0; i < NUM_CH; i++) begin
        count_q[i] <= count_d[i];
      end
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_out
    assign count_out[g*NUM_BITS +: NUM_BITS] = count_q[g];
  end

  assign rollover_flag = flag_q;
  assign overrun       = ovr_q;
  assign block_done    = done_q;

endmodule
